// File: rtl/spike_detect_axis.sv
// AXI-Stream running-mean spike detector: sliding-window mean per sample plus
// a spike flag when a sample departs from the previous mean by more than thr.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   threshold        spike threshold, taken with each accepted sample
//   clear            synchronous flush of window, fill state and spike counter
//   s_axis_*         input sample stream (data/valid/ready)
//   m_axis_data      floor mean of the window including the current sample
//   m_axis_user      [0] spike, [1] window full
//   m_axis_valid/_ready output stream handshake
//   spike_count      saturating number of emitted spikes
module spike_detect_axis #(
    parameter int DATA_W   = 32,
    parameter int LOG2_WIN = 3,
    parameter int MODE     = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] threshold,
    input  logic              clear,
    input  logic [DATA_W-1:0] s_axis_data,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    output logic [DATA_W-1:0] m_axis_data,
    output logic [1:0]        m_axis_user,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    output logic [CNT_W-1:0]  spike_count
);

    localparam int N     = 2 ** LOG2_WIN;
    localparam int SUM_W = DATA_W + LOG2_WIN;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [SUM_W-1:0]    sum_q, sum_d, sum_nxt;
    logic [LOG2_WIN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_WIN-1:0] fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0]   win_q [N];

    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic [1:0]        muser_q, muser_d;
    logic              mvalid_q, mvalid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              fill_last;
    logic              full_out;
    logic              spike_en;
    logic              spike_raw;
    logic              spike;
    logic [DATA_W-1:0] old;
    logic [DATA_W-1:0] mean_old;

    // Single output register: a new sample may enter whenever the held
    // output is empty or leaving this cycle. Clear blocks intake.
    assign s_axis_ready = (~mvalid_q | m_axis_ready) & ~clear;
    assign accept       = s_axis_valid & s_axis_ready;

    assign fill_last = (fill_cnt_q == LOG2_WIN'(N - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: if (accept && fill_last) state_d = RUN;
                RUN:  state_d = RUN;
                default: state_d = FILL;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        spike_en = 1'b0;
        full_out = 1'b0;
        case (state_q)
            FILL: begin
                spike_en = 1'b0;
                full_out = fill_last;
            end
            RUN: begin
                spike_en = 1'b1;
                full_out = 1'b1;
            end
            default: begin
                spike_en = 1'b0;
                full_out = 1'b0;
            end
        endcase
    end

    // While filling, the RAM holds stale data from before the last flush,
    // so the evicted value is taken as zero.
    assign old      = (state_q == RUN) ? win_q[wr_ptr_q] : '0;
    assign sum_nxt  = sum_q - SUM_W'(old) + SUM_W'(s_axis_data);
    assign mean_old = DATA_W'(sum_q >> LOG2_WIN);

    generate
        if (MODE == 0) begin : g_above
            // One extra bit so mean+thr cannot wrap.
            logic [DATA_W:0] limit;
            assign limit     = {1'b0, mean_old} + {1'b0, threshold};
            assign spike_raw = ({1'b0, s_axis_data} > limit);
        end else begin : g_abs
            logic [DATA_W-1:0] dev;
            assign dev = (s_axis_data >= mean_old) ?
                         (s_axis_data - mean_old) :
                         (mean_old - s_axis_data);
            assign spike_raw = (dev > threshold);
        end
    endgenerate

    assign spike = spike_raw & spike_en;

    // ---------------- datapath next state ----------------
    always_comb begin
        sum_d      = sum_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        cnt_d      = cnt_q;
        mdata_d    = mdata_q;
        muser_d    = muser_q;
        mvalid_d   = mvalid_q;

        if (clear) begin
            sum_d      = '0;
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
            cnt_d      = '0;
        end else if (accept) begin
            sum_d    = sum_nxt;
            wr_ptr_d = wr_ptr_q + LOG2_WIN'(1);
            if (state_q == FILL) begin
                fill_cnt_d = fill_cnt_q + LOG2_WIN'(1);
            end
            if (spike && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Held output survives a clear; it only leaves on a transfer.
        if (accept) begin
            mvalid_d = 1'b1;
            mdata_d  = DATA_W'(sum_nxt >> LOG2_WIN);
            muser_d  = {full_out, spike};
        end else if (m_axis_ready) begin
            mvalid_d = 1'b0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            cnt_q      <= '0;
            mdata_q    <= '0;
            muser_q    <= '0;
            mvalid_q   <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            cnt_q      <= cnt_d;
            mdata_q    <= mdata_d;
            muser_q    <= muser_d;
            mvalid_q   <= mvalid_d;
        end
    end

    // Window storage carries no reset; FILL masks its contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q[wr_ptr_q] <= s_axis_data;
        end
    end

    assign m_axis_data  = mdata_q;
    assign m_axis_user  = muser_q;
    assign m_axis_valid = mvalid_q;
    assign spike_count  = cnt_q;

endmodule

// File: tb/tb_spike_detect_axis.sv
// Bench for spike_detect_axis: both spike modes side by side on one stream,
// table vectors, directed corner sequences and a queue-based reference model.
module tb_spike_detect_axis;

    localparam int DW   = 16;
    localparam int LW   = 2;
    localparam int NW   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          clear = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] thr = '0;
    logic [DW-1:0] s_data = '0;

    logic          s_ready0, s_ready1;
    logic [DW-1:0] m_data0, m_data1;
    logic [1:0]    user0, user1;
    logic          mv0, mv1;
    logic [CW-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    spike_detect_axis #(
        .DATA_W(DW), .LOG2_WIN(LW), .MODE(0), .CNT_W(CW)
    ) u_m0 (
        .clk(clk), .resetn(resetn), .threshold(thr), .clear(clear),
        .s_axis_data(s_data), .s_axis_valid(s_valid),
        .s_axis_ready(s_ready0), .m_axis_data(m_data0),
        .m_axis_user(user0), .m_axis_valid(mv0),
        .m_axis_ready(m_ready), .spike_count(cnt0)
    );

    spike_detect_axis #(
        .DATA_W(DW), .LOG2_WIN(LW), .MODE(1), .CNT_W(CW)
    ) u_m1 (
        .clk(clk), .resetn(resetn), .threshold(thr), .clear(clear),
        .s_axis_data(s_data), .s_axis_valid(s_valid),
        .s_axis_ready(s_ready1), .m_axis_data(m_data1),
        .m_axis_user(user1), .m_axis_valid(mv1),
        .m_axis_ready(m_ready), .spike_count(cnt1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: accepted samples since the last flush, capped at NW.
    longint hist[$];
    bit     e_mv;
    longint e_data;
    bit     e_full;
    bit     e_sp0, e_sp1;
    int     e_c0, e_c1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        hist.delete();
        e_mv   = 1'b0;
        e_data = 0;
        e_full = 1'b0;
        e_sp0  = 1'b0;
        e_sp1  = 1'b0;
        e_c0   = 0;
        e_c1   = 0;
    endtask

    function automatic longint hsum();
        longint s = 0;
        foreach (hist[i]) s += hist[i];
        return s;
    endfunction

    task automatic m_accept(longint x, longint t);
        longint mo, dev;
        bit     run;
        run = (hist.size() == NW);
        mo  = hsum() / NW;
        dev = (x > mo) ? x - mo : mo - x;
        e_sp0 = run && (x > mo + t);
        e_sp1 = run && (dev > t);
        hist.push_back(x);
        if (hist.size() > NW) void'(hist.pop_front());
        e_data = hsum() / NW;
        e_full = (hist.size() == NW);
        if (e_sp0 && e_c0 < CMAX) e_c0++;
        if (e_sp1 && e_c1 < CMAX) e_c1++;
        e_mv = 1'b1;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        bit rdy, acc;
        #1;
        rdy = (!e_mv || m_ready) && !clear;
        chk("s_ready0", s_ready0, rdy);
        chk("s_ready1", s_ready1, rdy);
        acc = s_valid && rdy;
        if (clear) begin
            hist.delete();
            e_c0 = 0;
            e_c1 = 0;
            if (m_ready) e_mv = 1'b0;
        end else if (acc) begin
            m_accept(longint'(s_data), longint'(thr));
        end else if (m_ready) begin
            e_mv = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("m_valid0", mv0, e_mv);
        chk("m_valid1", mv1, e_mv);
        chk("m_data0", m_data0, e_data);
        chk("m_data1", m_data1, e_data);
        chk("user0", user0, {e_full, e_sp0});
        chk("user1", user1, {e_full, e_sp1});
        chk("count0", cnt0, e_c0);
        chk("count1", cnt1, e_c1);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_valid0"}, mv0, 0);
        chk({nm, "_valid1"}, mv1, 0);
        chk({nm, "_data0"}, m_data0, 0);
        chk({nm, "_data1"}, m_data1, 0);
        chk({nm, "_user0"}, user0, 0);
        chk({nm, "_user1"}, user1, 0);
        chk({nm, "_count0"}, cnt0, 0);
        chk({nm, "_count1"}, cnt1, 0);
    endtask

    typedef struct {
        int unsigned x;
        int unsigned data;
        bit          full;
        bit          sp0;
        bit          sp1;
        int          c0;
        int          c1;
    } vec_t;

    vec_t tbl[22];
    int   held;

    initial begin
        tbl[0]  = '{10,   2, 0, 0, 0, 0, 0};
        tbl[1]  = '{10,   5, 0, 0, 0, 0, 0};
        tbl[2]  = '{10,   7, 0, 0, 0, 0, 0};
        tbl[3]  = '{10,  10, 1, 0, 0, 0, 0};
        tbl[4]  = '{200, 57, 1, 1, 1, 1, 1};
        tbl[5]  = '{110, 82, 1, 0, 0, 1, 1};
        tbl[6]  = '{10,  82, 1, 0, 0, 1, 1};
        tbl[7]  = '{10,  82, 1, 0, 0, 1, 1};
        tbl[8]  = '{10,  35, 1, 0, 0, 1, 1};
        tbl[9]  = '{10,  10, 1, 0, 0, 1, 1};
        tbl[10] = '{110, 35, 1, 0, 0, 1, 1};
        tbl[11] = '{10,  35, 1, 0, 0, 1, 1};
        tbl[12] = '{10,  35, 1, 0, 0, 1, 1};
        tbl[13] = '{10,  35, 1, 0, 0, 1, 1};
        tbl[14] = '{10,  10, 1, 0, 0, 1, 1};
        tbl[15] = '{111, 35, 1, 1, 1, 2, 2};
        tbl[16] = '{200, 82, 1, 1, 1, 3, 3};
        tbl[17] = '{200,130, 1, 1, 1, 4, 4};
        tbl[18] = '{200,177, 1, 0, 0, 4, 4};
        tbl[19] = '{200,200, 1, 0, 0, 4, 4};
        tbl[20] = '{50, 162, 1, 0, 1, 4, 5};
        tbl[21] = '{150,150, 1, 0, 0, 4, 5};

        m_reset();
        #1;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Directed vectors: fill, spike, equality, abs mode.
        thr     = 16'd100;
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            s_data = DW'(tbl[i].x);
            cycle();
            chk("tbl_valid", mv0, 1);
            chk("tbl_data0", m_data0, tbl[i].data);
            chk("tbl_data1", m_data1, tbl[i].data);
            chk("tbl_user0", user0, {tbl[i].full, tbl[i].sp0});
            chk("tbl_user1", user1, {tbl[i].full, tbl[i].sp1});
            chk("tbl_count0", cnt0, tbl[i].c0);
            chk("tbl_count1", cnt1, tbl[i].c1);
        end

        // Back-pressure: held output stays put, nothing enters.
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_data = DW'(77 + k);
            cycle();
            chk("bp_valid", mv0, 1);
            chk("bp_hold", m_data0, 150);
            chk("bp_sready", s_ready0, 0);
        end
        m_ready = 1'b1;
        s_data  = 16'd300;
        cycle();
        chk("bp_release", m_data0, 175);
        s_valid = 1'b0;
        cycle();
        chk("bp_drain", mv0, 0);

        // Clear while an output is held, then a fresh window.
        s_valid = 1'b1;
        s_data  = 16'd1000;
        for (int k = 0; k < 6; k++) cycle();
        m_ready = 1'b0;
        clear   = 1'b1;
        s_data  = 16'd999;
        cycle();
        chk("clr_held", mv0, 1);
        chk("clr_count", cnt0, 0);
        clear   = 1'b0;
        m_ready = 1'b1;
        s_data  = 16'd4;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("clr_data", m_data0, k + 1);
            chk("clr_full", user0[1], (k == 3));
            chk("clr_spk", cnt0, 0);
        end

        // Reset in the middle of a burst.
        s_data = 16'd500;
        cycle();
        #2 resetn = 1'b0;
        #1;
        chk_zero("midrst");
        m_reset();
        @(negedge clk);
        resetn = 1'b1;
        s_data = 16'd8;
        cycle();
        chk("midrst_fresh", m_data0, 2);

        // Saturation of the spike counter with a rising ramp.
        thr = '0;
        for (int k = 1; k < 34; k++) begin
            s_data = DW'(100 * k);
            cycle();
        end
        chk("sat0", cnt0, CMAX);
        chk("sat1", cnt1, CMAX);

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            m_ready = ($urandom_range(0, 9) < 7);
            clear   = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 3) == 0)
                thr = DW'($urandom_range(0, 65535));
            else
                thr = DW'($urandom_range(0, 300));
            if ($urandom_range(0, 4) == 0)
                s_data = DW'($urandom_range(60000, 65535));
            else
                s_data = DW'($urandom_range(0, 600));
            cycle();
        end
        clear   = 1'b0;
        s_valid = 1'b0;

        held = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
